// File: rtl/sa_ctrl_pkg.sv
// Shared types and helpers for the systolic array feed controller.
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Cycles spent in DRAIN minus one: the last operand must ripple through the
  // far corner of the array and then through the PE pipeline.
  function automatic int unsigned drain_len(input int unsigned rows,
                                            input int unsigned cols,
                                            input int unsigned pe_lat);
    return rows + cols + pe_lat - 2;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage data+valid delay line used to build the diagonal operand skew.
module sa_skew_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  if (DEPTH == 0) begin : g_wire
    assign data_o  = data_i;
    assign valid_o = valid_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic             valid_q [DEPTH];

    // Shift data and valid together; reset flushes every stage.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          data_q[s]  <= '0;
          valid_q[s] <= 1'b0;
        end
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int unsigned s = 1; s < DEPTH; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feed_controller.sv
// Sequences one tile: clears the array, streams K operand vectors with a
// diagonal skew, waits for the array to drain, then pulses done_o.
module systolic_feed_controller
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 32,
  parameter int unsigned WEIGHT_WIDTH = 32,
  parameter int unsigned NUM_ROWS     = 16,
  parameter int unsigned NUM_COLS     = 16,
  parameter int unsigned K_MAX        = 1024,
  parameter int unsigned PE_LAT       = 1,
  parameter int unsigned K_W          = $clog2(K_MAX + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [K_W-1:0]                   k_len_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             rd_en_o,
  output logic [K_W-1:0]                   rd_addr_o,
  input  logic [INPUT_WIDTH*NUM_ROWS-1:0]  a_rd_data_i,
  input  logic [WEIGHT_WIDTH*NUM_COLS-1:0] b_rd_data_i,
  output logic                             arr_clear_o,
  output logic [INPUT_WIDTH*NUM_ROWS-1:0]  arr_input_o,
  output logic [NUM_ROWS-1:0]              arr_input_valid_o,
  output logic [WEIGHT_WIDTH*NUM_COLS-1:0] arr_weight_o,
  output logic [NUM_COLS-1:0]              arr_weight_valid_o
);

  localparam int unsigned DRAIN_LEN = drain_len(NUM_ROWS, NUM_COLS, PE_LAT);
  localparam int unsigned DR_W      = (DRAIN_LEN < 1) ? 1 : $clog2(DRAIN_LEN + 1);
  localparam logic [K_W-1:0]  K_MAX_V = K_W'(K_MAX);
  localparam logic [DR_W-1:0] DRAIN_V = DR_W'(DRAIN_LEN);

  state_e          state_q, state_d;
  logic [K_W-1:0]  addr_q;
  logic [K_W-1:0]  k_last_q;
  logic [DR_W-1:0] drain_q;
  logic            rd_valid_q;
  logic [K_W-1:0]  k_eff;

  assign k_eff = (k_len_i > K_MAX_V) ? K_MAX_V : k_len_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = (k_len_i == '0) ? DONE : FETCH;
      FETCH: if (addr_q == k_last_q) state_d = DRAIN;
      DRAIN: if (drain_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, length and drain counters; rd_valid_q tracks the read latency.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      k_last_q   <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == FETCH);
      unique case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (start_i && (k_len_i != '0)) k_last_q <= k_eff - K_W'(1);
        end
        FETCH: begin
          if (addr_q == k_last_q) drain_q <= DRAIN_V;
          else                    addr_q  <= addr_q + K_W'(1);
        end
        DRAIN: if (drain_q != '0) drain_q <= drain_q - DR_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the clear coincides with the first read.
  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    rd_en_o     = (state_q == FETCH);
    rd_addr_o   = (state_q == FETCH) ? addr_q : '0;
    arr_clear_o = (state_q == FETCH) && (addr_q == '0);
  end

  // Operands are zeroed before the skew so idle lanes always carry data=0.
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    logic [INPUT_WIDTH-1:0] lane;
    assign lane = rd_valid_q ? a_rd_data_i[i*INPUT_WIDTH +: INPUT_WIDTH] : '0;
    sa_skew_line #(.WIDTH(INPUT_WIDTH), .DEPTH(i)) u_skew (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .data_i  (lane),
      .valid_i (rd_valid_q),
      .data_o  (arr_input_o[i*INPUT_WIDTH +: INPUT_WIDTH]),
      .valid_o (arr_input_valid_o[i])
    );
  end

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    logic [WEIGHT_WIDTH-1:0] lane;
    assign lane = rd_valid_q ? b_rd_data_i[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
    sa_skew_line #(.WIDTH(WEIGHT_WIDTH), .DEPTH(j)) u_skew (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .data_i  (lane),
      .valid_i (rd_valid_q),
      .data_o  (arr_weight_o[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .valid_o (arr_weight_valid_o[j])
    );
  end

endmodule
